// File: rtl/quad_encoder_counter.sv
// Quadrature A/B/Z decoder: synchronise, debounce, 4x decode, wrap-around up/down count.
// Optional index clear is built only when QENC_INDEX_EN is defined.
module quad_encoder_counter #(
  parameter int WIDTH       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             A,
  input  logic             B,
  input  logic             Z,
  input  logic             Clr,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Enc,
  output logic             Dir,
  output logic             Step,
  output logic             Err,
  output logic             IdxSeen
);

`ifdef QENC_INDEX_EN
  localparam int NPIN = 3;
`else
  localparam int NPIN = 2;
`endif

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int ICW = $clog2(FILT_LEN + SYNC_STAGES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(FILT_LEN + SYNC_STAGES);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  logic [NPIN-1:0] raw_pins;
  logic [NPIN-1:0] filt;

`ifdef QENC_INDEX_EN
  assign raw_pins = {Z, B, A};
`else
  assign raw_pins = {B, A};
  logic z_unused;
  assign z_unused = Z;
`endif

  // Per pin: synchroniser chain, then a change is accepted only after FILT_LEN stable clocks.
  for (genvar p = 0; p < NPIN; p++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCW-1:0]         cnt_q;
    logic                   filt_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_pins[p]};
        if (sync_q[SYNC_STAGES-1] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FILT_LAST) begin
          filt_q <= sync_q[SYNC_STAGES-1];
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + FCW'(1);
        end
      end
    end

    assign filt[p] = filt_q;
  end

  logic [1:0] cur_ab;
  assign cur_ab = {filt[0], filt[1]};

  state_t           state_q, state_d;
  logic [ICW-1:0]   init_cnt_q, init_cnt_d;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic [WIDTH-1:0] enc_d;
  logic             dir_d, step_d, err_d, idx_seen_d;
  logic             step_up, step_dn, illegal;
  logic             index_hit;

`ifdef QENC_INDEX_EN
  logic z_prev_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) z_prev_q <= 1'b0;
    else     z_prev_q <= filt[2];
  end
  // Index only counts while both channels sit high, so it lands on one fixed quadrature state.
  assign index_hit = (state_q == ST_TRACK) && filt[2] && !z_prev_q && filt[0] && filt[1];
`else
  assign index_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    enc_d      = Enc;
    dir_d      = Dir;
    step_d     = 1'b0;
    err_d      = Err;
    idx_seen_d = IdxSeen;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          prev_ab_d = cur_ab;
          state_d   = ST_TRACK;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      ST_TRACK: begin
        prev_ab_d = cur_ab;
        case ({prev_ab_q, cur_ab})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn = 1'b1;
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_INIT;
    endcase

    if (illegal)     err_d = 1'b1;
    else if (ErrClr) err_d = 1'b0;

    if (Clr) begin
      enc_d = '0;
    end else if (index_hit) begin
      enc_d      = '0;
      idx_seen_d = 1'b1;
    end else if (step_up) begin
      enc_d  = Enc + WIDTH'(1);
      dir_d  = 1'b1;
      step_d = 1'b1;
    end else if (step_dn) begin
      enc_d  = Enc - WIDTH'(1);
      dir_d  = 1'b0;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_ab_q  <= 2'b00;
      Enc        <= '0;
      Dir        <= 1'b0;
      Step       <= 1'b0;
      Err        <= 1'b0;
      IdxSeen    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      Enc        <= enc_d;
      Dir        <= dir_d;
      Step       <= step_d;
      Err        <= err_d;
      IdxSeen    <= idx_seen_d;
    end
  end

endmodule
